// File: rtl/hog_block_sequencer.sv
// Builds overlapping 2x2 HOG blocks (stride 1 cell) from a raster-ordered cell histogram stream.
// Optional macro HOG_BLOCK_SEQ_STATS_EN adds the per-frame blk_count handshake counter.
module hog_block_sequencer #(
  parameter int BIN_WIDTH     = 14,
  parameter int BINS          = 9,
  parameter int CELLS_PER_ROW = 80,
  parameter int CELL_ROWS     = 60
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cell_valid,
  output logic                                 cell_ready,
  input  logic [(BINS+1)*BIN_WIDTH-1:0]        cell_hist,
  output logic                                 blk_valid,
  input  logic                                 blk_ready,
  output logic [4*(BINS+1)*BIN_WIDTH-1:0]      block_histograms,
  output logic                                 k_border,
  output logic                                 frame_done
`ifdef HOG_BLOCK_SEQ_STATS_EN
  ,
  output logic [15:0]                          blk_count
`endif
);

  localparam int CELL_W = (BINS + 1) * BIN_WIDTH;
  localparam int COL_W  = (CELLS_PER_ROW > 1) ? $clog2(CELLS_PER_ROW) : 1;
  localparam int ROW_W  = (CELL_ROWS > 1) ? $clog2(CELL_ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(CELLS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(CELL_ROWS - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // Valid and payload stay stable until that transfer; ready may depend on blk_ready.

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [CELL_W-1:0] rowbuf [CELLS_PER_ROW];
  logic [CELL_W-1:0] rowbuf_rd;
  logic [CELL_W-1:0] left;
  logic [CELL_W-1:0] top_left;
  logic              accept;
  logic              emit;
  logic              col_last;
  logic              row_last;

  // A single output slot; any cell, emitting or not, waits while a block is stuck.
  assign cell_ready = !blk_valid || blk_ready;
  assign accept     = cell_valid && cell_ready;
  assign col_last   = (col == LAST_COL);
  assign row_last   = (row == LAST_ROW);
  assign emit       = accept && (row != '0) && (col != '0);
  assign rowbuf_rd  = rowbuf[col];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Row buffer and neighbour registers need no reset: row 0 rewrites every
  // entry before any of it can feed a block.
  always_ff @(posedge clk) begin
    if (accept) begin
      rowbuf[col] <= cell_hist;
      left        <= cell_hist;
      top_left    <= rowbuf_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_valid        <= 1'b0;
      block_histograms <= '0;
      k_border         <= 1'b0;
    end else if (emit) begin
      blk_valid        <= 1'b1;
      block_histograms <= {cell_hist, left, rowbuf_rd, top_left};
      k_border         <= col_last;
    end else if (blk_ready) begin
      blk_valid        <= 1'b0;
    end
  end

`ifdef HOG_BLOCK_SEQ_STATS_EN
  logic blk_hs;
  assign blk_hs = blk_valid && blk_ready;

  // A handshake in the frame_done cycle is the first count of the new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (frame_done) begin
      blk_count <= blk_hs ? 16'd1 : 16'd0;
    end else if (blk_hs && (blk_count != 16'hFFFF)) begin
      blk_count <= blk_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hog_block_sequencer.sv
// Directed bench for hog_block_sequencer on a 4x3-cell frame; cell n carries value n in every field.
module tb_hog_block_sequencer;

  localparam int BW     = 14;
  localparam int NB     = 9;
  localparam int CPR    = 4;
  localparam int CR     = 3;
  localparam int CELL_W = (NB + 1) * BW;
  localparam int BLK_W  = 4 * CELL_W;
  localparam int EW     = BLK_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cell_valid;
  logic              cell_ready;
  logic [CELL_W-1:0] cell_hist;
  logic              blk_valid;
  logic              blk_ready;
  logic [BLK_W-1:0]  block_histograms;
  logic              k_border;
  logic              frame_done;
`ifdef HOG_BLOCK_SEQ_STATS_EN
  logic [15:0]       blk_count;
`endif

  hog_block_sequencer #(
    .BIN_WIDTH(BW), .BINS(NB), .CELLS_PER_ROW(CPR), .CELL_ROWS(CR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_hist(cell_hist), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .block_histograms(block_histograms), .k_border(k_border), .frame_done(frame_done)
`ifdef HOG_BLOCK_SEQ_STATS_EN
    , .blk_count(blk_count)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int next_cell = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int fd_q[$];

  function automatic logic [CELL_W-1:0] mk_cell(input int n);
    logic [CELL_W-1:0] c;
    for (int j = 0; j <= NB; j++) c[j*BW +: BW] = BW'(n);
    return c;
  endfunction

  function automatic logic [EW-1:0] blk(input int tl, input int tr, input int bl, input int br,
                                        input bit k);
    return {k, mk_cell(br), mk_cell(bl), mk_cell(tr), mk_cell(tl)};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sample away from the rising edge; inputs settle at posedge+1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (blk_valid && blk_ready) obs_q.push_back({k_border, block_histograms});
      if (frame_done) fd_q.push_back(next_cell - 1);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    fd_q.delete();
  endtask

  // Blocks of one 4x3 frame whose first cell has value base.
  task automatic add_frame(input int base);
    exp_q.push_back(blk(base+0, base+1, base+4,  base+5,  1'b0));
    exp_q.push_back(blk(base+1, base+2, base+5,  base+6,  1'b0));
    exp_q.push_back(blk(base+2, base+3, base+6,  base+7,  1'b1));
    exp_q.push_back(blk(base+4, base+5, base+8,  base+9,  1'b0));
    exp_q.push_back(blk(base+5, base+6, base+9,  base+10, 1'b0));
    exp_q.push_back(blk(base+6, base+7, base+10, base+11, 1'b1));
  endtask

  // mode 0: valid and ready held high; mode 1: random valid, ready toggling each cycle.
  task automatic stream(input int first, input int last, input int mode);
    int n = first;
    int cyc = 0;
    bit acc;
    bit tog = 1'b0;
    while (n <= last && cyc < 400) begin
      cell_hist = mk_cell(n);
      if (mode == 0) begin
        cell_valid = 1'b1;
        blk_ready  = 1'b1;
      end else begin
        cell_valid = 1'($urandom_range(0, 1));
        blk_ready  = tog;
        tog        = !tog;
      end
      @(negedge clk);
      acc = cell_valid && cell_ready;
      step();
      if (acc) begin
        n++;
        next_cell = n;
      end
      cyc++;
    end
    check("stream_budget", n, last + 1);
    cell_valid = 1'b0;
  endtask

  task automatic drain();
    cell_valid = 1'b0;
    blk_ready  = 1'b1;
    repeat (4) step();
  endtask

  task automatic rst_pulse();
    rst_n      = 1'b0;
    cell_valid = 1'b0;
    step();
    rst_n = 1'b1;
    next_cell = 0;
  endtask

  task automatic compare_blocks(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check(tag, obs_q[i], exp_q[i]);
  endtask

  initial begin
    rst_n      = 1'b0;
    cell_valid = 1'b0;
    blk_ready  = 1'b0;
    cell_hist  = '0;
    repeat (2) step();

    // Reset values
    @(negedge clk);
    check("rst_cell_ready", cell_ready, 1);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_k_border", k_border, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_block", block_histograms, 0);
`ifdef HOG_BLOCK_SEQ_STATS_EN
    check("rst_blk_count", blk_count, 0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // Scenario 1: one frame, no back-pressure
    clear_sb();
    stream(0, 11, 0);
    drain();
    add_frame(0);
    compare_blocks("s1_blocks");
    if (obs_q.size() == 6) begin
      check("s1_first", obs_q[0], blk(0, 1, 4, 5, 1'b0));
      check("s1_last", obs_q[5], blk(6, 7, 10, 11, 1'b1));
    end
    check("s1_fd_count", fd_q.size(), 1);
    if (fd_q.size() >= 1) check("s1_fd_cell", fd_q[0], 11);

    // Scenario 2: first block held under back-pressure
    clear_sb();
    stream(0, 4, 0);
    check("s2_no_block_row0_col0", blk_valid, 0);
    stream(5, 5, 0);
    check("s2_first_latency", blk_valid, 1);
    check("s2_first_data", {k_border, block_histograms}, blk(0, 1, 4, 5, 1'b0));
    for (int i = 0; i < 5; i++) begin
      cell_valid = 1'b1;
      cell_hist  = mk_cell(6);
      blk_ready  = 1'b0;
      @(negedge clk);
      check("s2_hold_ready", cell_ready, 0);
      check("s2_hold_valid", blk_valid, 1);
      check("s2_hold_data", {k_border, block_histograms}, blk(0, 1, 4, 5, 1'b0));
      step();
    end
    stream(6, 11, 0);
    drain();
    add_frame(0);
    compare_blocks("s2_blocks");

    // Scenario 3: ready toggling, random valid
    clear_sb();
    stream(0, 11, 1);
    drain();
    add_frame(0);
    compare_blocks("s3_blocks");

    // Scenario 4: two frames back to back
    clear_sb();
    stream(0, 23, 0);
    drain();
    add_frame(0);
    add_frame(12);
    compare_blocks("s4_blocks");
    if (obs_q.size() >= 7) check("s4_frame2_first", obs_q[6], blk(12, 13, 16, 17, 1'b0));
    check("s4_fd_count", fd_q.size(), 2);
    if (fd_q.size() == 2) begin
      check("s4_fd_first", fd_q[0], 11);
      check("s4_fd_second", fd_q[1], 23);
    end

    // Scenario 5: reset mid-frame after cell 6
    stream(0, 6, 0);
    rst_pulse();
    @(negedge clk);
    check("s5_rst_valid", blk_valid, 0);
    check("s5_rst_ready", cell_ready, 1);
    check("s5_rst_fd", frame_done, 0);
    step();
    clear_sb();
    stream(0, 11, 0);
    drain();
    add_frame(0);
    compare_blocks("s5_blocks");

`ifdef HOG_BLOCK_SEQ_STATS_EN
    // Stats: the frame's last block is valid in the frame_done cycle, so holding
    // ready low there leaves 5 counted in the old frame and 1 in the new one.
    rst_pulse();
    stream(0, 10, 0);
    check("st_mid", blk_count, 4);
    cell_valid = 1'b1;
    cell_hist  = mk_cell(11);
    blk_ready  = 1'b1;
    step();
    next_cell  = 12;
    cell_valid = 1'b0;
    blk_ready  = 1'b0;
    @(negedge clk);
    check("st_fd_high", frame_done, 1);
    check("st_before_fd", blk_count, 5);
    step();
    @(negedge clk);
    check("st_after_fd", blk_count, 0);
    check("st_last_pending", blk_valid, 1);
    step();
    blk_ready = 1'b1;
    step();
    @(negedge clk);
    check("st_new_frame", blk_count, 1);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
